// File: rtl/ram_arb.sv
// Three-master Wishbone arbiter in front of the PSRAM bridge slave port.
// Round-robin grant per tenure, with a strobe timeout that aborts a stalled tenure.
module ram_arb #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk2x_i,
    input  logic        reset_in,
    input  logic [2:0]  m_cyc_i,
    input  logic [2:0]  m_stb_i,
    input  logic [2:0]  m_we_i,
    input  logic [68:0] m_adr_i,
    input  logic [5:0]  m_sel_i,
    input  logic [47:0] m_dat_i,
    output logic [15:0] m_dat_o,
    output logic [2:0]  m_ack_o,
    output logic [2:0]  m_err_o,
    output logic [2:0]  gnt_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [22:0] s_adr_o,
    output logic [1:0]  s_sel_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_rst_i
);

    localparam int unsigned NM = 3;
    localparam int unsigned AW = 23;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, BUSY, ERR, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [NM-1:0]   gnt_q, gnt_d;
    logic [1:0]      last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [1:0]      win;
    logic            win_vld;
    logic            cyc_g, stb_g, we_g;
    logic [AW-1:0]   adr_g;
    logic [SW-1:0]   sel_g;
    logic [DW-1:0]   dat_g;

    // Round-robin pick: search starts one past the last granted master
    always_comb begin
        win     = 2'd0;
        win_vld = |m_cyc_i;
        case (last_q)
            2'd0: begin
                if (m_cyc_i[1])      win = 2'd1;
                else if (m_cyc_i[2]) win = 2'd2;
                else                 win = 2'd0;
            end
            2'd1: begin
                if (m_cyc_i[2])      win = 2'd2;
                else if (m_cyc_i[0]) win = 2'd0;
                else                 win = 2'd1;
            end
            default: begin
                if (m_cyc_i[0])      win = 2'd0;
                else if (m_cyc_i[1]) win = 2'd1;
                else                 win = 2'd2;
            end
        endcase
    end

    // last_q doubles as the index of the master holding the current tenure
    always_comb begin
        cyc_g = m_cyc_i[2];
        stb_g = m_stb_i[2];
        we_g  = m_we_i[2];
        adr_g = m_adr_i[68:46];
        sel_g = m_sel_i[5:4];
        dat_g = m_dat_i[47:32];
        case (last_q)
            2'd0: begin
                cyc_g = m_cyc_i[0];
                stb_g = m_stb_i[0];
                we_g  = m_we_i[0];
                adr_g = m_adr_i[22:0];
                sel_g = m_sel_i[1:0];
                dat_g = m_dat_i[15:0];
            end
            2'd1: begin
                cyc_g = m_cyc_i[1];
                stb_g = m_stb_i[1];
                we_g  = m_we_i[1];
                adr_g = m_adr_i[45:23];
                sel_g = m_sel_i[3:2];
                dat_g = m_dat_i[31:16];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (!s_rst_i && win_vld) begin
                    state_d = BUSY;
                    gnt_d   = NM'(1) << win;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (s_ack_i)
                    cnt_d = '0;
                else if (stb_g && (cnt_q != '1))
                    cnt_d = cnt_q + CW'(1);
                // A same-cycle ack beats the timeout
                if (!cyc_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (s_rst_i) begin
                    state_d = ERR;
                end else if ((cnt_q == CW'(TIMEOUT)) && !s_ack_i) begin
                    state_d = ERR;
                end
            end
            ERR: state_d = DRAIN;
            DRAIN: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk2x_i or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave bus and acks pass through only during an active tenure
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state_q == BUSY) begin
            s_cyc_o = cyc_g;
            s_stb_o = stb_g;
            s_we_o  = we_g;
            s_adr_o = adr_g;
            s_sel_o = sel_g;
            s_dat_o = dat_g;
            m_ack_o = gnt_q & m_stb_i & {NM{s_ack_i}};
        end
        if (state_q == ERR)
            m_err_o = gnt_q;
    end

    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: arbitration order, pass-through, timeout,
// bridge-not-ready handling and asynchronous reset.
module tb_ram_arb;

    logic        clk2x_i, reset_in;
    logic [2:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [68:0] m_adr_i;
    logic [5:0]  m_sel_i;
    logic [47:0] m_dat_i;
    logic [15:0] m_dat_o;
    logic [2:0]  m_ack_o, m_err_o, gnt_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [22:0] s_adr_o;
    logic [1:0]  s_sel_o;
    logic [15:0] s_dat_o, s_dat_i;
    logic        s_ack_i, s_rst_i;

    int errors = 0;
    int checks = 0;

    ram_arb #(.TIMEOUT(63)) dut (
        .clk2x_i(clk2x_i), .reset_in(reset_in),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_rst_i(s_rst_i)
    );

    initial begin
        clk2x_i = 1'b0;
        forever #5 clk2x_i = ~clk2x_i;
    end

    task automatic tick();
        @(posedge clk2x_i);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_rst_i = 1'b0;
        #2;
        checks++; if ({gnt_o, m_ack_o, m_err_o} !== 9'b0) begin errors++;
            $display("FAIL reset_masters: got %b want 0", {gnt_o, m_ack_o, m_err_o}); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o} !== 44'b0) begin errors++;
            $display("FAIL reset_slave: got %h want 0", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}); end
        m_cyc_i = 3'b111; m_stb_i = 3'b111;
        tick(); tick();
        @(negedge clk2x_i);
        checks++; if ({gnt_o, s_cyc_o} !== 4'b0) begin errors++;
            $display("FAIL reset_held_gnt: got %b want 0", {gnt_o, s_cyc_o}); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        tick();
        reset_in = 1'b1;
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b000) begin errors++;
            $display("FAIL rr_pre_gnt: got %b want 000", gnt_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            s_ack_i = 1'b1;
            @(negedge clk2x_i);
            checks++; if ({gnt_o, m_ack_o} !== {exp_g[i], exp_g[i]}) begin errors++;
                $display("FAIL rr_grant%0d: got gnt/ack %b want %b", i, {gnt_o, m_ack_o}, {exp_g[i], exp_g[i]}); end
            tick();
            s_ack_i = 1'b0;
            m_cyc_i = 3'b111 & ~exp_g[i];
            @(negedge clk2x_i);
            checks++; if ({gnt_o, m_ack_o} !== {exp_g[i], 3'b000}) begin errors++;
                $display("FAIL rr_release%0d: got gnt/ack %b want %b", i, {gnt_o, m_ack_o}, {exp_g[i], 3'b000}); end
            tick();
            m_cyc_i = (i < 3) ? 3'b111 : 3'b000;
            @(negedge clk2x_i);
            checks++; if (gnt_o !== 3'b000) begin errors++;
                $display("FAIL rr_dead%0d: got %b want 000", i, gnt_o); end
        end
        m_stb_i = '0;
    endtask

    task automatic test_read();
        tick();
        m_cyc_i = 3'b010; m_stb_i = 3'b010; m_we_i = 3'b000;
        m_adr_i[22:0] = 23'h000AAA; m_adr_i[45:23] = 23'h012345; m_adr_i[68:46] = 23'h055555;
        s_dat_i = 16'h0000;
        tick();
        @(negedge clk2x_i);
        checks++; if ({gnt_o, s_cyc_o, s_we_o, s_adr_o} !== {3'b010, 1'b1, 1'b0, 23'h012345}) begin errors++;
            $display("FAIL read_grant: got gnt %b cyc %b we %b adr %h want 010 1 0 012345", gnt_o, s_cyc_o, s_we_o, s_adr_o); end
        repeat (5) tick();
        s_ack_i = 1'b1; s_dat_i = 16'hBEEF;
        @(negedge clk2x_i);
        checks++; if ({m_ack_o, m_dat_o, s_adr_o} !== {3'b010, 16'hBEEF, 23'h012345}) begin errors++;
            $display("FAIL read_ack: got ack %b dat %h adr %h want 010 beef 012345", m_ack_o, m_dat_o, s_adr_o); end
        tick();
        s_ack_i = 1'b0; s_dat_i = '0; m_cyc_i = '0; m_stb_i = '0;
        @(negedge clk2x_i);
        checks++; if (m_ack_o !== 3'b000) begin errors++;
            $display("FAIL read_ack_once: got %b want 000", m_ack_o); end
        tick();
        @(negedge clk2x_i);
        checks++; if ({gnt_o, s_cyc_o, s_adr_o} !== 27'b0) begin errors++;
            $display("FAIL read_idle: got gnt %b cyc %b adr %h want 0", gnt_o, s_cyc_o, s_adr_o); end
    endtask

    task automatic test_write();
        tick();
        m_cyc_i = 3'b100; m_stb_i = 3'b100; m_we_i = 3'b100;
        m_dat_i = {16'hA5C3, 16'h2222, 16'h1111};
        m_sel_i = {2'b01, 2'b11, 2'b11};
        m_adr_i[68:46] = 23'h070F0F;
        tick();
        @(negedge clk2x_i);
        checks++; if ({gnt_o, s_we_o, s_sel_o, s_dat_o, s_adr_o} !== {3'b100, 1'b1, 2'b01, 16'hA5C3, 23'h070F0F}) begin errors++;
            $display("FAIL write_fwd: got gnt %b we %b sel %b dat %h adr %h want 100 1 01 a5c3 070f0f",
                     gnt_o, s_we_o, s_sel_o, s_dat_o, s_adr_o); end
        tick();
        s_ack_i = 1'b1;
        @(negedge clk2x_i);
        checks++; if (m_ack_o !== 3'b100) begin errors++;
            $display("FAIL write_ack: got %b want 100", m_ack_o); end
        tick();
        s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        tick();
        @(negedge clk2x_i);
        checks++; if ({gnt_o, s_we_o, s_sel_o, s_dat_o} !== 22'b0) begin errors++;
            $display("FAIL write_idle: got gnt %b we %b sel %b dat %h want 0", gnt_o, s_we_o, s_sel_o, s_dat_o); end
    endtask

    task automatic test_back_to_back();
        tick();
        m_cyc_i = 3'b001; m_stb_i = 3'b001;
        tick();
        m_cyc_i = 3'b111; s_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk2x_i);
            checks++; if ({gnt_o, m_ack_o} !== 6'b001_001) begin errors++;
                $display("FAIL b2b_ack%0d: got gnt/ack %b want 001001", k, {gnt_o, m_ack_o}); end
            tick();
        end
        s_ack_i = 1'b0; m_cyc_i = 3'b110;
        @(negedge clk2x_i);
        checks++; if ({gnt_o, m_ack_o} !== 6'b001_000) begin errors++;
            $display("FAIL b2b_release: got gnt/ack %b want 001000", {gnt_o, m_ack_o}); end
        tick();
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b000) begin errors++;
            $display("FAIL b2b_dead: got %b want 000", gnt_o); end
        tick();
        m_cyc_i = '0; m_stb_i = '0;
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b010) begin errors++;
            $display("FAIL b2b_next: got %b want 010", gnt_o); end
        tick();
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b000) begin errors++;
            $display("FAIL b2b_idle: got %b want 000", gnt_o); end
    endtask

    task automatic test_timeout();
        tick();
        m_cyc_i = 3'b001; m_stb_i = 3'b001; s_ack_i = 1'b0;
        tick();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk2x_i);
            checks++; if ({m_err_o, s_stb_o, gnt_o} !== 7'b000_1_001) begin errors++;
                $display("FAIL to_wait%0d: got err/stb/gnt %b want 0001001", k, {m_err_o, s_stb_o, gnt_o}); end
            tick();
        end
        @(negedge clk2x_i);
        checks++; if ({m_err_o, s_cyc_o, s_stb_o, gnt_o} !== 8'b001_0_0_001) begin errors++;
            $display("FAIL to_err: got err/cyc/stb/gnt %b want 00100001", {m_err_o, s_cyc_o, s_stb_o, gnt_o}); end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk2x_i);
            checks++; if ({m_err_o, s_cyc_o, s_stb_o, gnt_o} !== 8'b000_0_0_001) begin errors++;
                $display("FAIL to_drain%0d: got err/cyc/stb/gnt %b want 00000001", k, {m_err_o, s_cyc_o, s_stb_o, gnt_o}); end
        end
        tick();
        m_cyc_i = '0; m_stb_i = '0;
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b001) begin errors++;
            $display("FAIL to_drain_hold: got %b want 001", gnt_o); end
        tick();
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b000) begin errors++;
            $display("FAIL to_idle: got %b want 000", gnt_o); end
    endtask

    task automatic test_ack_race();
        tick();
        m_cyc_i = 3'b001; m_stb_i = 3'b001;
        tick();
        repeat (63) tick();
        s_ack_i = 1'b1;
        @(negedge clk2x_i);
        checks++; if ({m_ack_o, m_err_o} !== 6'b001_000) begin errors++;
            $display("FAIL race_ack: got ack/err %b want 001000", {m_ack_o, m_err_o}); end
        tick();
        s_ack_i = 1'b0;
        @(negedge clk2x_i);
        checks++; if ({m_err_o, s_stb_o, gnt_o} !== 7'b000_1_001) begin errors++;
            $display("FAIL race_stay: got err/stb/gnt %b want 0001001", {m_err_o, s_stb_o, gnt_o}); end
        tick();
        m_cyc_i = '0; m_stb_i = '0;
        tick();
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b000) begin errors++;
            $display("FAIL race_idle: got %b want 000", gnt_o); end
    endtask

    task automatic test_slave_not_ready();
        tick();
        s_rst_i = 1'b1; m_cyc_i = 3'b100; m_stb_i = 3'b100;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk2x_i);
            checks++; if ({gnt_o, s_cyc_o} !== 4'b0) begin errors++;
                $display("FAIL snr_hold%0d: got gnt/cyc %b want 0000", k, {gnt_o, s_cyc_o}); end
        end
        tick();
        s_rst_i = 1'b0;
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b000) begin errors++;
            $display("FAIL snr_fall: got %b want 000", gnt_o); end
        tick();
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b100) begin errors++;
            $display("FAIL snr_grant: got %b want 100", gnt_o); end
        tick();
        s_rst_i = 1'b1;
        @(negedge clk2x_i);
        checks++; if (m_err_o !== 3'b000) begin errors++;
            $display("FAIL snr_busy_noerr: got %b want 000", m_err_o); end
        tick();
        @(negedge clk2x_i);
        checks++; if ({m_err_o, s_cyc_o} !== 4'b100_0) begin errors++;
            $display("FAIL snr_err: got err/cyc %b want 1000", {m_err_o, s_cyc_o}); end
        tick();
        m_cyc_i = '0; m_stb_i = '0; s_rst_i = 1'b0;
        @(negedge clk2x_i);
        checks++; if ({m_err_o, gnt_o} !== 6'b000_100) begin errors++;
            $display("FAIL snr_drain: got err/gnt %b want 000100", {m_err_o, gnt_o}); end
        tick();
        @(negedge clk2x_i);
        checks++; if (gnt_o !== 3'b000) begin errors++;
            $display("FAIL snr_idle: got %b want 000", gnt_o); end
    endtask

    task automatic test_async_reset();
        tick();
        m_cyc_i = 3'b001; m_stb_i = 3'b001;
        tick();
        s_ack_i = 1'b1;
        @(negedge clk2x_i);
        checks++; if ({gnt_o, m_ack_o} !== 6'b001_001) begin errors++;
            $display("FAIL ar_pre: got gnt/ack %b want 001001", {gnt_o, m_ack_o}); end
        #1;
        reset_in = 1'b0;
        #1;
        checks++; if ({gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o} !== 11'b0) begin errors++;
            $display("FAIL ar_immediate: got %b want 0", {gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o}); end
        s_ack_i = 1'b0; m_cyc_i = 3'b011; m_stb_i = 3'b011;
        tick();
        @(negedge clk2x_i);
        checks++; if ({gnt_o, m_ack_o, m_err_o} !== 9'b0) begin errors++;
            $display("FAIL ar_held: got %b want 0", {gnt_o, m_ack_o, m_err_o}); end
        tick();
        reset_in = 1'b1;
        @(negedge clk2x_i);
        checks++; if ({gnt_o, m_err_o} !== 6'b0) begin errors++;
            $display("FAIL ar_release: got gnt/err %b want 0", {gnt_o, m_err_o}); end
        tick();
        @(negedge clk2x_i);
        checks++; if ({gnt_o, m_err_o} !== 6'b001_000) begin errors++;
            $display("FAIL ar_regrant: got gnt/err %b want 001000", {gnt_o, m_err_o}); end
        tick();
        m_cyc_i = '0; m_stb_i = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_ack_race();
        test_slave_not_ready();
        test_async_reset();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
- REQ-001 The block SHALL have parameter TIMEOUT, default 63: the number of consecutive un-acknowledged strobe cycles after which a tenure is aborted (legal range 1..255).
- REQ-002 The block SHALL have these ports (port, direction, width, meaning):
  - clk2x_i  in  1  sole clock; all state changes on its rising edge.
  - reset_in  in  1  asynchronous, active-low reset.
  - m_cyc_i  in  3  per-master Wishbone cycle request; bit n is master n.
  - m_stb_i  in  3  per-master strobe.
  - m_we_i  in  3  per-master write enable.
  - m_adr_i  in  69  per-master word address [23:1]; master n is bits [23n+22:23n].
  - m_sel_i  in  6  per-master byte selects; master n is bits [2n+1:2n].
  - m_dat_i  in  48  per-master write data; master n is bits [16n+15:16n].
  - m_dat_o  out  16  read data, broadcast to all masters.
  - m_ack_o  out  3  per-master acknowledge.
  - m_err_o  out  3  per-master error (timeout abort).
  - gnt_o  out  3  one-hot registered grant; zero when no tenure is active.
  - s_cyc_o, s_stb_o, s_we_o  out  1 each  to the PSRAM bridge slave port.
  - s_adr_o  out  23  address to the bridge.
  - s_sel_o  out  2  byte selects to the bridge.
  - s_dat_o  out  16  write data to the bridge.
  - s_dat_i  in  16  read data from the bridge.
  - s_ack_i  in  1  acknowledge from the bridge.
  - s_rst_i  in  1  bridge not ready (power-up wait or BCR configuration in progress).

Function
- REQ-003 The block SHALL implement the states IDLE, BUSY, ERR and DRAIN, encoded in a registered state register.
- REQ-004 IDLE: with s_rst_i=0 and any m_cyc_i bit set, the block SHALL select a winner by round-robin and register it into gnt_o, then enter BUSY at the next edge.
- REQ-005 Round-robin order SHALL be last+1, last+2, last+3 (mod 3), where last is the most recently granted master; last SHALL update on every grant.
- REQ-006 IDLE with s_rst_i=1 SHALL grant nothing and remain in IDLE, whatever the m_cyc_i inputs.
- REQ-007 BUSY: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o and s_dat_o SHALL combinationally follow the granted master's inputs.
- REQ-008 BUSY: m_ack_o[g] SHALL equal s_ack_i & m_stb_i[g] for the granted master g, and all other m_ack_o bits SHALL be 0.
- REQ-009 m_dat_o SHALL equal s_dat_i at all times.
- REQ-010 Outside BUSY, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL all be 0, and m_ack_o SHALL be 0.
- REQ-011 The tenure SHALL be held while m_cyc_i[g]=1, and back-to-back strobes SHALL pass without re-arbitration.
- REQ-012 When m_cyc_i[g] falls in BUSY, the block SHALL clear gnt_o and enter IDLE at the next edge, giving exactly one dead cycle before the next grant.
- REQ-013 Timeout counter, 8 bits:
  - cleared on entry to BUSY and on every s_ack_i;
  - incremented on each BUSY cycle with s_stb_o=1 and s_ack_i=0;
  - saturating.
- REQ-014 In BUSY, the block SHALL enter ERR at the next edge when either:
  - the timeout counter equals TIMEOUT and s_ack_i=0; or
  - s_rst_i=1.
- REQ-015 If s_ack_i and the timeout condition occur in the same cycle, the ack SHALL win and the block SHALL remain in BUSY.
- REQ-016 ERR SHALL last exactly one cycle with m_err_o[g]=1 and the slave bus idle, then go to DRAIN.
- REQ-017 DRAIN SHALL hold gnt_o and keep the slave bus idle until m_cyc_i[g]=0, then go to IDLE.
- REQ-018 At most one m_ack_o or m_err_o bit SHALL be high in any cycle.
- REQ-019 gnt_o SHALL always be one-hot or zero.

Reset
- REQ-020 reset_in=0 SHALL asynchronously force the following, with all outputs driven 0 thereafter until the first grant:
  - state=IDLE;
  - gnt_o=0;
  - last=2, so master 0 wins first;
  - timeout counter=0.
- REQ-021 Reset asserted mid-tenure SHALL abort the tenure with no m_ack_o or m_err_o pulse.

Verification
- REQ-022 Release reset with m_cyc_i=3'b111 held -> grants in the order 001, 010, 100, 001, each separated by one idle cycle as each master drops cyc after one ack.
- REQ-023 Master 1 performs a read, bridge acks after 5 cycles with s_dat_i=16'hBEEF -> m_ack_o=3'b010 for one cycle, m_dat_o=16'hBEEF, s_adr_o equal to master 1's address.
- REQ-024 With TIMEOUT=63, master 0 strobes and the bridge never acks -> m_err_o=3'b001 exactly one cycle, on the 65th cycle after grant; slave bus idle afterwards; gnt_o=001 until m_cyc_i[0] falls.
- REQ-025 s_rst_i=1 with m_cyc_i=3'b100 -> gnt_o stays 0; one cycle after s_rst_i falls -> gnt_o=100.
- REQ-026 s_ack_i rises on the same cycle the counter reaches TIMEOUT -> m_ack_o pulses and m_err_o stays 0; reset_in pulsed low mid-BUSY -> gnt_o=0 and all outputs 0 immediately.
